instr_encoder: RTL
==================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader. It accepts abstract instruction requests over a valid/ready handshake, packs each into a 32-bit MIPS word using the same opcode set the control decoder recognises (R-type, LW, SW, BEQ, ADDI, J, LB), and writes the words to consecutive instruction-memory addresses. It sits between a test or boot source and the imem write port, producing programs the single-cycle datapath then decodes.

## Interface
Parameters:
- `ADDR_W`, default 6: imem word-address width; depth = 2^ADDR_W.
- `BASE`, default 0: first write address after `start`.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new load session.
- `req_valid` in 1: request present.
- `req_ready` out 1: encoder can accept a request.
- `req_kind` in 3: instruction kind (`kind_t`).
- `req_rs`, `req_rt`, `req_rd` in 5 each: register fields.
- `req_funct` in 6: R-type funct.
- `req_imm` in 16: I-type immediate.
- `req_target` in 26: J target.
- `req_last` in 1: final instruction of the program.
- `imem_we` out 1: imem write strobe.
- `imem_addr` out ADDR_W: imem word address.
- `imem_wd` out 32: encoded word.
- `count` out ADDR_W+1: words written this session.
- `busy`, `done`, `err` out 1 each: status flags.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: `req_ready`=0. `start` clears `count`, loads the address register with BASE, and moves to ACCEPT.
- ACCEPT: `req_ready`=1.
  - On `req_valid`&`req_ready` with a legal kind: register the encoded word, the address, and `req_last`, then go to WRITE.
  - Kind 7 is illegal: no write, go to ERROR.
- WRITE: `imem_we`=1 for exactly one cycle, driving the registered address and data. The address increments modulo 2^ADDR_W and `count` increments. Next state:
  - DONE if the latched last flag is set;
  - otherwise ERROR if `count` is now 2^ADDR_W (overflow);
  - otherwise ACCEPT.
- DONE and ERROR are sticky. `start` restarts a session from DONE, ERROR or IDLE. `start` is ignored in ACCEPT and WRITE.
- Encoding rules:
  - RTYPE: {000000, rs, rt, rd, 00000, funct}.
  - LW 100011, SW 101011, BEQ 000100, ADDI 001000, LB 100000: {op, rs, rt, imm}.
  - J: {000010, target}.
  - Fields not used by a kind are ignored.
  - `req_funct` is passed through unchecked.
- `busy` = state is ACCEPT or WRITE. `done` = state is DONE. `err` = state is ERROR.

## Timing
- All outputs are registered or decoded directly from state. Reset value of every output is 0, and state is IDLE.
- A request handshaken in cycle N produces `imem_we`=1 in cycle N+1. `req_ready` is 0 in cycle N+1.
- Peak throughput is one word per 2 cycles.
- `count` and `imem_addr` update at the end of the WRITE cycle.
- `done` or `err` rises in the cycle after the final or overflowing WRITE.
- `req_valid` without `req_ready` has no effect, and the request fields are not sampled.
- Reset asserted mid-WRITE drops `imem_we` asynchronously. The partially written word is the imem's concern.
- BASE≠0: writes wrap to address 0 after 2^ADDR_W−1. Overflow is still judged by `count`.

## Structure
- Shared package `mips_pkg`:
  - `kind_t` enum: RTYPE=0, LW=1, SW=2, BEQ=3, ADDI=4, J=5, LB=6.
  - 6-bit opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_LB, shared with the control decoder.
  - State enum.
- One combinational sub-module `instr_pack`: kind plus fields in, 32-bit word and `legal` out. The FSM, counters and registers live in `instr_encoder`.

## Test plan
- `start`; ADDI rs=0 rt=8 imm=5 -> `imem_we` at addr 0 with wd=0x20080005; `count`=1; back in ACCEPT.
- Then R-type rs=8 rt=9 rd=10 funct=0x20 -> 0x01095020 @1; LW rs=0 rt=2 imm=4 -> 0x8C020004 @2; J target=0x10 with last -> 0x08000010 @3. Then `done`=1, `count`=4, `req_ready`=0.
- BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF; SW rs=29 rt=31 imm=8 -> 0xAFBF0008; LB rs=4 rt=5 imm=1 -> 0x80850001. Each write is exactly 2 cycles apart under back-to-back valid.
- Kind 7 -> no `imem_we`, `err`=1. Then `start` -> `err`=0, `count`=0, next write at BASE.
- ADDR_W=2, five requests without last -> writes at 0..3; `err`=1 after the 4th write; `count`=4; 5th request never accepted.
- `reset` low during WRITE -> `imem_we` and all flags 0 immediately, state IDLE. `start` pulsed while in ACCEPT -> `count` unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: instruction kinds, opcodes and the
// loader FSM state set. The opcode constants are also used by the control decoder.
package mips_pkg;

    // Abstract instruction kinds accepted by the encoder; encoding 7 is illegal.
    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        LW    = 3'd1,
        SW    = 3'd2,
        BEQ   = 3'd3,
        ADDI  = 3'd4,
        J     = 3'd5,
        LB    = 3'd6
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LB    = 6'b100000;

    // Loader session states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns an instruction kind plus its fields into a
// 32-bit MIPS word. Fields a kind does not use are ignored; funct is unchecked.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Select the instruction format and opcode for the requested kind.
    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (kind_i)
            RTYPE:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            LW:      word_o = {OP_LW,   rs_i, rt_i, imm_i};
            SW:      word_o = {OP_SW,   rs_i, rt_i, imm_i};
            BEQ:     word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
            ADDI:    word_o = {OP_ADDI, rs_i, rt_i, imm_i};
            LB:      word_o = {OP_LB,   rs_i, rt_i, imm_i};
            J:       word_o = {OP_J,    target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder and imem loader. Accepts abstract requests
// over valid/ready, packs them, and writes the words to consecutive imem
// addresses starting at BASE, one word per two cycles at best.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wd_q, wd_d;
    logic              last_q, last_d;

    logic [31:0]       pack_word;
    logic              pack_legal;
    logic [ADDR_W:0]   count_inc;

    instr_pack u_pack (
        .kind_i   (req_kind),
        .rs_i     (req_rs),
        .rt_i     (req_rt),
        .rd_i     (req_rd),
        .funct_i  (req_funct),
        .imm_i    (req_imm),
        .target_i (req_target),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    assign count_inc = count_q + CNT_ONE;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside an active session.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (req_valid) state_d = pack_legal ? ST_WRITE : ST_ERROR;
            end
            ST_WRITE: begin
                if (last_q)                     state_d = ST_DONE;
                else if (count_inc == CNT_FULL) state_d = ST_ERROR;
                else                            state_d = ST_ACCEPT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from state so reset clears them asynchronously.
    always_comb begin
        req_ready = (state_q == ST_ACCEPT);
        imem_we   = (state_q == ST_WRITE);
        busy      = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
        done      = (state_q == ST_DONE);
        err       = (state_q == ST_ERROR);
    end

    // Datapath next values: session setup, request capture, post-write advance.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        wd_d    = wd_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                end
            end
            ST_ACCEPT: begin
                if (req_valid && pack_legal) begin
                    wd_d   = pack_word;
                    last_d = req_last;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_ONE;
                count_d = count_inc;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            count_q <= '0;
            wd_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
        end
    end

    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign count     = count_q;

endmodule
